// File: rtl/guess_input_conditioner.sv
// Synchronises the guess switches and confirm button, debounces the button and emits
// one confirm (or reject) pulse per clean press. Optional macro: GUESS_DISTINCT_CHECK_EN.
module guess_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [15:0] sw_raw_i,
    input  logic        confirm_raw_i,
    output logic [15:0] guess_o,
    output logic        confirm_o,
    output logic        reject_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_RELEASED  = 2'd0;
    localparam logic [1:0] ST_PRESS_CHK = 2'd1;
    localparam logic [1:0] ST_PRESSED   = 2'd2;
    localparam logic [1:0] ST_REL_CHK   = 2'd3;

    logic [15:0]      swMeta_q;
    logic [15:0]      swSync_q;
    logic             btnMeta_q;
    logic             btnSync_q;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept;
    logic             digitsDistinct;
    logic [15:0]      guess_q;
    logic [15:0]      guess_d;
    logic             confirm_q;
    logic             confirm_d;
    logic             reject_q;
    logic             reject_d;

    // Two-flop synchronisers; nothing below this point looks at the raw pins.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            swMeta_q  <= '0;
            swSync_q  <= '0;
            btnMeta_q <= 1'b0;
            btnSync_q <= 1'b0;
        end else begin
            swMeta_q  <= sw_raw_i;
            swSync_q  <= swMeta_q;
            btnMeta_q <= confirm_raw_i;
            btnSync_q <= btnMeta_q;
        end
    end

    // Debounce FSM: accept fires only on the PRESS_CHK -> PRESSED transition,
    // so holding the button can never retrigger until a debounced release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (btnSync_q) begin
                    state_d = ST_PRESS_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PRESS_CHK: begin
                if (!btnSync_q) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!btnSync_q) begin
                    state_d = ST_REL_CHK;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_REL_CHK: begin
                if (btnSync_q) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_PRESSED;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef GUESS_DISTINCT_CHECK_EN
    // Any repeated digit (A-F included) refuses the guess.
    assign digitsDistinct = (swSync_q[15:12] != swSync_q[11:8]) &&
                            (swSync_q[15:12] != swSync_q[7:4])  &&
                            (swSync_q[15:12] != swSync_q[3:0])  &&
                            (swSync_q[11:8]  != swSync_q[7:4])  &&
                            (swSync_q[11:8]  != swSync_q[3:0])  &&
                            (swSync_q[7:4]   != swSync_q[3:0]);
`else
    assign digitsDistinct = 1'b1;
`endif

    always_comb begin
        confirm_d = accept & digitsDistinct;
        reject_d  = accept & ~digitsDistinct;
        guess_d   = confirm_d ? swSync_q : guess_q;
    end

    // Reset lands in PRESSED so a button held through reset must be released first.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_PRESSED;
            cnt_q     <= '0;
            guess_q   <= 16'h0000;
            confirm_q <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            guess_q   <= guess_d;
            confirm_q <= confirm_d;
            reject_q  <= reject_d;
        end
    end

    assign guess_o   = guess_q;
    assign confirm_o = confirm_q;
    assign reject_o  = reject_q;

endmodule

// File: tb/tb_guess_input_conditioner.sv
// Bench for guess_input_conditioner with DEBOUNCE_CYCLES=4: press vectors from a table,
// expected pulses queued at drive time and matched by a monitor after every clock edge.
module tb_guess_input_conditioner;

    localparam int unsigned DEB = 4;
`ifdef GUESS_DISTINCT_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [15:0] sw_raw;
    logic        confirm_raw;
    logic [15:0] guess_o;
    logic        confirm_o;
    logic        reject_o;

    typedef struct {
        logic [15:0] sw;
        logic [15:0] swIdle;
        logic [15:0] pat;
        int          patLen;
        int          hold;
        bit          expPulse;
        int          expEdge;
        bit          dup;
    } vec_t;

    typedef struct {
        int          edgeNum;
        logic [15:0] guess;
        bit          isReject;
    } exp_t;

    exp_t        expQ[$];
    vec_t        vecs[10];
    int          cyc = 0;
    int          nVec = 0;
    int          nMiss = 0;
    logic [15:0] curGuess = 16'h0000;

    guess_input_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clock_i       (clock),
        .reset_i       (reset),
        .sw_raw_i      (sw_raw),
        .confirm_raw_i (confirm_raw),
        .guess_o       (guess_o),
        .confirm_o     (confirm_o),
        .reject_o      (reject_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nVec = nVec + 1;
        if (actual !== expected) begin
            nMiss = nMiss + 1;
            $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge and matches pulses against the queue.
    always @(posedge clock) begin
        exp_t e;
        cyc = cyc + 1;
        #1;
        if (!reset) begin
            if (confirm_o || reject_o) begin
                checkOutput("pulseExclusive", int'(confirm_o & reject_o), 0);
                if (expQ.size() == 0) begin
                    nVec = nVec + 1;
                    nMiss = nMiss + 1;
                    $display("[TB] FAIL unexpectedPulse at edge %0d: got confirm=%0b reject=%0b, expected no pulse",
                             cyc, confirm_o, reject_o);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("pulseEdge", cyc, e.edgeNum);
                    checkOutput("pulseIsReject", int'(reject_o), int'(e.isReject));
                    if (!e.isReject) curGuess = e.guess;
                end
            end
            checkOutput("guessValue", int'(guess_o), int'(curGuess));
        end
    end

    // Drives one table vector from a falling edge, then releases and idles long enough
    // for the release to debounce; any queued pulse still pending at the end was missed.
    task automatic applyStimulus(input vec_t v);
        int start;
        sw_raw = v.sw;
        start  = cyc + 1;
        if (v.expPulse) expQ.push_back('{start + v.expEdge, v.sw, v.dup && CHECK_EN});
        for (int i = 0; i < v.patLen; i++) begin
            confirm_raw = v.pat[i];
            @(negedge clock);
        end
        for (int i = 0; i < v.hold; i++) begin
            confirm_raw = 1'b1;
            @(negedge clock);
        end
        confirm_raw = 1'b0;
        sw_raw      = v.swIdle;
        repeat (12) @(negedge clock);
        checkOutput("pulsesPending", expQ.size(), 0);
        expQ.delete();
    endtask

    initial begin
        int start;
        //             sw        swIdle    pat       len hold pulse edge dup
        vecs[0] = '{16'h1234, 16'h5678, 16'h0001,  1, 19, 1'b1,  5, 1'b0};
        vecs[1] = '{16'h5678, 16'h5678, 16'h0001,  1,  9, 1'b1,  5, 1'b0};
        vecs[2] = '{16'h9ABC, 16'h9ABC, 16'h002D,  6, 10, 1'b1, 10, 1'b0};
        vecs[3] = '{16'hDEF0, 16'hDEF0, 16'h0007,  3,  0, 1'b0,  0, 1'b0};
        vecs[4] = '{16'h1357, 16'h1357, 16'h0001,  1,  0, 1'b0,  0, 1'b0};
        vecs[5] = '{16'h0F1E, 16'h0F1E, 16'h000F,  4,  0, 1'b1,  5, 1'b0};
        vecs[6] = '{16'h1123, 16'h1123, 16'h0001,  1,  9, 1'b1,  5, 1'b1};
        vecs[7] = '{16'hAACF, 16'hAACF, 16'h0001,  1,  9, 1'b1,  5, 1'b1};
        vecs[8] = '{16'h3456, 16'h3456, 16'h02FF, 10, 10, 1'b1,  5, 1'b0};
        vecs[9] = '{16'hFEDC, 16'hFEDC, 16'h0001,  1,  9, 1'b1,  5, 1'b0};

        reset       = 1'b1;
        sw_raw      = 16'h0000;
        confirm_raw = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("resetGuess", int'(guess_o), 0);
        checkOutput("resetConfirm", int'(confirm_o), 0);
        checkOutput("resetReject", int'(reject_o), 0);
        reset = 1'b0;
        repeat (8) @(negedge clock);

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

        // Reset while PRESS_CHK with the button held: pending accept is lost, and the
        // still-held button must be released and pressed again before any confirm.
        sw_raw      = 16'h2468;
        confirm_raw = 1'b1;
        repeat (3) @(negedge clock);
        reset    = 1'b1;
        curGuess = 16'h0000;
        expQ.delete();
        #1;
        checkOutput("midResetGuess", int'(guess_o), 0);
        checkOutput("midResetConfirm", int'(confirm_o), 0);
        checkOutput("midResetReject", int'(reject_o), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        confirm_raw = 1'b0;
        repeat (8) @(negedge clock);
        checkOutput("heldThroughResetNoPulse", expQ.size(), 0);
        start = cyc + 1;
        expQ.push_back('{start + 5, 16'h2468, 1'b0});
        confirm_raw = 1'b1;
        repeat (10) @(negedge clock);
        confirm_raw = 1'b0;
        repeat (12) @(negedge clock);
        checkOutput("repressPending", expQ.size(), 0);
        checkOutput("repressGuess", int'(guess_o), 16'h2468);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
